fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Fetch-stage PC generator and IF/ID pipeline register.
- Holds the fetch PC and drives it to instruction memory.
- Selects the next PC from three sources: sequential (PC+4), the static jump/branch prediction computed in fetch, or a redirect from execute when a misprediction is resolved.
- Registers the fetched instruction, its PC, PC+4 and the predicted-taken flag into decode.
- Handles stall and flush, and counts redirects for performance monitoring.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 16, width of the saturating redirect counter.

Ports:
iClk  input  1  clock, all state updates on rising edge
iRst  input  1  asynchronous active-high reset
oPCF  output  32  current fetch PC, to instruction memory address
iInstructionF  input  32  instruction read combinationally at oPCF
iTakeJBF  input  1  fetch-stage prediction: jump/branch taken
iJBOffsetF  input  32  sign-extended byte offset of predicted target, relative to oPCF
iStallF  input  1  hold PC and IF/ID register (hazard unit)
iRedirectE  input  1  execute resolved a misprediction; fetch must restart
iRedirectPCE  input  32  correct PC from execute
oInstrD  output  32  registered instruction to decode
oPCD  output  32  registered PC of oInstrD
oPCPlus4D  output  32  registered PC+4 of oInstrD
oPredTakenD  output  1  registered iTakeJBF, for execute to check prediction
oValidD  output  1  IF/ID holds a real instruction (0 = bubble)
oRedirectCount  output  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset (async, iRst=1):
  - PC = RESET_PC.
  - oInstrD = 32'h0000_0013 (NOP).
  - oPCD = 0, oPCPlus4D = 0.
  - oPredTakenD = 0, oValidD = 0.
  - oRedirectCount = 0.
- Reset deasserted mid-operation: the first edge after release fetches RESET_PC. No stale redirect or stall is remembered.
- Next-PC priority, evaluated every edge:
  1. iRedirectE → PC = {iRedirectPCE[31:2], 2'b00}.
  2. iStallF → PC holds.
  3. iTakeJBF → PC = oPCF + iJBOffsetF, force [1:0]=0.
  4. otherwise → PC = oPCF + 4.
- Arithmetic is 32-bit modulo 2^32. PC+4 at 32'hFFFF_FFFC wraps to 0. A negative offset wraps likewise.
- IF/ID register, same priority:
  - iRedirectE: flush. oValidD=0, oInstrD=NOP, oPredTakenD=0; oPCD/oPCPlus4D don't-care but must be deterministic (load 0).
  - iStallF (no redirect): all IF/ID outputs hold.
  - otherwise: load oInstrD=iInstructionF, oPCD=oPCF, oPCPlus4D=oPCF+4, oPredTakenD=iTakeJBF, oValidD=1.
- Latency: an instruction presented at oPCF in cycle N appears at the IF/ID outputs in cycle N+1. A redirect asserted in cycle N makes oPCF=target in cycle N+1 and its instruction valid in decode in cycle N+2.
- Predicted-taken jump: the wrong-path instruction is not fetched. The jump itself enters IF/ID with oPredTakenD=1, and the next oPCF is the target (zero-bubble prediction).
- Simultaneous redirect and stall: redirect wins for both PC and IF/ID.
- Simultaneous redirect and iTakeJBF: redirect wins; the prediction is discarded.
- oRedirectCount increments by 1 on each edge with iRedirectE=1 and saturates at all-ones (no wrap).
- Outputs are registered except oPCF, which is the PC register output directly.

Test Plan:
- Reset then 3 free-running edges, iTakeJBF=0, no stall → oPCF 0, 4, 8, C. Cycle 2: oPCD=0, oPCPlus4D=4, oValidD=1.
- At oPCF=0x10, iTakeJBF=1, iJBOffsetF=0xFFFF_FFF0 → next oPCF=0x0. Decode shows oPCD=0x10, oPredTakenD=1.
- iStallF=1 for 2 cycles at oPCF=0x20 → oPCF and all IF/ID outputs unchanged for both cycles. Release → oPCF=0x24.
- iRedirectE=1, iRedirectPCE=0x103, iStallF=1 in the same cycle → oPCF=0x100, oValidD=0, oInstrD=0x13, oRedirectCount=1.
- Force PC to 0xFFFF_FFFC via redirect, then a free edge → oPCF=0x0. oPCPlus4D of that instruction = 0x0.
- CNT_W=2, 5 consecutive redirects → oRedirectCount 1, 2, 3, 3, 3. Assert iRst mid-sequence → all outputs return to reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with IF/ID pipeline register.
// Redirect from execute outranks stall, which outranks the fetch-stage prediction.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             iClk,
   input  logic             iRst,
   output logic [31:0]      oPCF,
   input  logic [31:0]      iInstructionF,
   input  logic             iTakeJBF,
   input  logic [31:0]      iJBOffsetF,
   input  logic             iStallF,
   input  logic             iRedirectE,
   input  logic [31:0]      iRedirectPCE,
   output logic [31:0]      oInstrD,
   output logic [31:0]      oPCD,
   output logic [31:0]      oPCPlus4D,
   output logic             oPredTakenD,
   output logic             oValidD,
   output logic [CNT_W-1:0] oRedirectCount
);

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] WORD_MSK = 32'hFFFF_FFFC;

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      pc_plus4;
   logic [31:0]      instr_q, pcd_q, pcp4d_q;
   logic             pred_q, valid_q;
   logic [CNT_W-1:0] cnt_q;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d = pc_plus4;
      if (iRedirectE)
         pc_d = iRedirectPCE & WORD_MSK;
      else if (iStallF)
         pc_d = pc_q;
      else if (iTakeJBF)
         pc_d = (pc_q + iJBOffsetF) & WORD_MSK;
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         pcd_q   <= 32'd0;
         pcp4d_q <= 32'd0;
         pred_q  <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pc_q <= pc_d;
         if (iRedirectE) begin
            // flush: PC fields are zeroed so a bubble is always bit-identical
            instr_q <= NOP;
            pcd_q   <= 32'd0;
            pcp4d_q <= 32'd0;
            pred_q  <= 1'b0;
            valid_q <= 1'b0;
            if (cnt_q != {CNT_W{1'b1}})
               cnt_q <= cnt_q + 1'b1;
         end else if (!iStallF) begin
            instr_q <= iInstructionF;
            pcd_q   <= pc_q;
            pcp4d_q <= pc_plus4;
            pred_q  <= iTakeJBF;
            valid_q <= 1'b1;
         end
      end
   end

   assign oPCF           = pc_q;
   assign oInstrD        = instr_q;
   assign oPCD           = pcd_q;
   assign oPCPlus4D      = pcp4d_q;
   assign oPredTakenD    = pred_q;
   assign oValidD        = valid_q;
   assign oRedirectCount = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table, randomized run
// against a behavioural model, and a narrow-counter instance for saturation/reset.
module tb_fetch_pc_unit;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] RPC2 = 32'h0000_1000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a ^ 32'hDEAD_0000) + 32'd7;
   endfunction

   // main instance, 16-bit counter, RESET_PC = 0
   logic        rst1, take1, stall1, redir1;
   logic [31:0] off1, rpc1, pc1, ins1, instrd1, pcd1, p4d1;
   logic        pred1, valid1;
   logic [15:0] cnt1;
   assign ins1 = imem(pc1);

   fetch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u1 (
      .iClk(clk), .iRst(rst1), .oPCF(pc1), .iInstructionF(ins1),
      .iTakeJBF(take1), .iJBOffsetF(off1), .iStallF(stall1),
      .iRedirectE(redir1), .iRedirectPCE(rpc1), .oInstrD(instrd1),
      .oPCD(pcd1), .oPCPlus4D(p4d1), .oPredTakenD(pred1),
      .oValidD(valid1), .oRedirectCount(cnt1));

   // second instance, 2-bit counter, nonzero RESET_PC
   logic        rst2, take2, stall2, redir2;
   logic [31:0] off2, rpc2, pc2, ins2, instrd2, pcd2, p4d2;
   logic        pred2, valid2;
   logic [1:0]  cnt2;
   assign ins2 = imem(pc2);

   fetch_pc_unit #(.RESET_PC(RPC2), .CNT_W(2)) u2 (
      .iClk(clk), .iRst(rst2), .oPCF(pc2), .iInstructionF(ins2),
      .iTakeJBF(take2), .iJBOffsetF(off2), .iStallF(stall2),
      .iRedirectE(redir2), .iRedirectPCE(rpc2), .oInstrD(instrd2),
      .oPCD(pcd2), .oPCPlus4D(p4d2), .oPredTakenD(pred2),
      .oValidD(valid2), .oRedirectCount(cnt2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_u1(input string tag, input logic [31:0] e_pc, input logic [31:0] e_pcd,
                           input logic [31:0] e_p4, input logic e_valid, input logic e_pred,
                           input logic [31:0] e_instr, input logic [31:0] e_cnt);
      check({tag, ".pcf"},   pc1,            e_pc);
      check({tag, ".pcd"},   pcd1,           e_pcd);
      check({tag, ".pcp4d"}, p4d1,           e_p4);
      check({tag, ".valid"}, {31'd0, valid1}, {31'd0, e_valid});
      check({tag, ".pred"},  {31'd0, pred1},  {31'd0, e_pred});
      check({tag, ".instr"}, instrd1,        e_instr);
      check({tag, ".cnt"},   {16'd0, cnt1},  e_cnt);
   endtask

   typedef struct {
      logic        redir;
      logic [31:0] rpc;
      logic        stall;
      logic        take;
      logic [31:0] off;
      logic [31:0] e_pc;
      logic [31:0] e_pcd;
      logic [31:0] e_p4;
      logic        e_valid;
      logic        e_pred;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs[18];

   // behavioural model for the random phase
   logic [31:0] m_pc, m_instr, m_pcd, m_p4, m_cnt;
   logic        m_pred, m_valid;

   initial begin
      vecs[0]  = '{0, 0, 0, 0, 0,            32'h4,        32'h0,        32'h4,  1, 0, 0};
      vecs[1]  = '{0, 0, 0, 0, 0,            32'h8,        32'h4,        32'h8,  1, 0, 0};
      vecs[2]  = '{0, 0, 0, 0, 0,            32'hC,        32'h8,        32'hC,  1, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 0,            32'h10,       32'hC,        32'h10, 1, 0, 0};
      vecs[4]  = '{0, 0, 0, 1, 32'hFFFF_FFF0, 32'h0,       32'h10,       32'h14, 1, 1, 0};
      vecs[5]  = '{1, 32'h1C, 0, 0, 0,       32'h1C,       32'h0,        32'h0,  0, 0, 1};
      vecs[6]  = '{0, 0, 0, 0, 0,            32'h20,       32'h1C,       32'h20, 1, 0, 1};
      vecs[7]  = '{0, 0, 1, 0, 0,            32'h20,       32'h1C,       32'h20, 1, 0, 1};
      vecs[8]  = '{0, 0, 1, 0, 0,            32'h20,       32'h1C,       32'h20, 1, 0, 1};
      vecs[9]  = '{0, 0, 0, 0, 0,            32'h24,       32'h20,       32'h24, 1, 0, 1};
      vecs[10] = '{1, 32'h103, 1, 0, 0,      32'h100,      32'h0,        32'h0,  0, 0, 2};
      vecs[11] = '{0, 0, 0, 0, 0,            32'h104,      32'h100,      32'h104, 1, 0, 2};
      vecs[12] = '{1, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,      32'h0,  0, 0, 3};
      vecs[13] = '{0, 0, 0, 0, 0,            32'h0,        32'hFFFF_FFFC, 32'h0, 1, 0, 3};
      vecs[14] = '{1, 32'h40, 0, 1, 32'h8,   32'h40,       32'h0,        32'h0,  0, 0, 4};
      vecs[15] = '{0, 0, 0, 1, 32'h8,        32'h48,       32'h40,       32'h44, 1, 1, 4};
      vecs[16] = '{0, 0, 1, 1, 32'h8,        32'h48,       32'h40,       32'h44, 1, 1, 4};
      vecs[17] = '{0, 0, 0, 1, 32'h3,        32'h48,       32'h48,       32'h4C, 1, 1, 4};

      rst1 = 1; take1 = 0; stall1 = 0; redir1 = 0; off1 = 0; rpc1 = 0;
      rst2 = 1; take2 = 0; stall2 = 0; redir2 = 0; off2 = 0; rpc2 = 0;
      repeat (2) @(negedge clk);
      check_u1("reset", 32'h0, 32'h0, 32'h0, 0, 0, NOP, 0);
      rst1 = 0;
      check_u1("reset_rel", 32'h0, 32'h0, 32'h0, 0, 0, NOP, 0);

      for (int i = 0; i < 18; i++) begin
         redir1 = vecs[i].redir; rpc1 = vecs[i].rpc; stall1 = vecs[i].stall;
         take1 = vecs[i].take; off1 = vecs[i].off;
         @(posedge clk); #1;
         check_u1($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_pcd, vecs[i].e_p4,
                  vecs[i].e_valid, vecs[i].e_pred,
                  vecs[i].e_valid ? imem(vecs[i].e_pcd) : NOP, vecs[i].e_cnt);
         @(negedge clk);
      end

      // randomized run against the model, seeded from the state left by the table
      m_pc = 32'h48; m_pcd = 32'h48; m_p4 = 32'h4C; m_valid = 1; m_pred = 1;
      m_instr = imem(32'h48); m_cnt = 4;
      for (int i = 0; i < 400; i++) begin
         redir1 = ($urandom_range(7) == 0);
         rpc1   = $urandom;
         stall1 = ($urandom_range(3) == 0);
         take1  = ($urandom_range(3) == 0);
         off1   = ($urandom_range(1) == 0) ? $urandom : 32'($signed($urandom_range(64)) - 32);
         if (redir1) begin
            m_pc = rpc1 & 32'hFFFF_FFFC;
            m_instr = NOP; m_pcd = 0; m_p4 = 0; m_pred = 0; m_valid = 0;
            if (m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
         end else if (!stall1) begin
            m_instr = imem(m_pc); m_pcd = m_pc; m_p4 = m_pc + 4;
            m_pred = take1; m_valid = 1;
            m_pc = take1 ? ((m_pc + off1) & 32'hFFFF_FFFC) : m_pc + 4;
         end
         @(posedge clk); #1;
         check_u1($sformatf("rnd%0d", i), m_pc, m_pcd, m_p4, m_valid, m_pred, m_instr, m_cnt);
         @(negedge clk);
      end
      redir1 = 0; stall1 = 0; take1 = 0;

      // narrow counter: saturation, then async reset mid-sequence
      rst2 = 0;
      for (int i = 0; i < 5; i++) begin
         redir2 = 1; rpc2 = 32'h200 + 32'(i * 16);
         @(posedge clk); #1;
         check($sformatf("sat%0d.cnt", i), {30'd0, cnt2}, (i < 3) ? 32'(i + 1) : 32'd3);
         check($sformatf("sat%0d.pcf", i), pc2, 32'h200 + 32'(i * 16));
         @(negedge clk);
      end
      #2 rst2 = 1;
      #1;
      check("arst.pcf",   pc2, RPC2);
      check("arst.cnt",   {30'd0, cnt2}, 32'd0);
      check("arst.instr", instrd2, NOP);
      check("arst.pcd",   pcd2, 32'd0);
      check("arst.pcp4d", p4d2, 32'd0);
      check("arst.vp",    {30'd0, valid2, pred2}, 32'd0);
      @(negedge clk);
      rst2 = 0; redir2 = 0; stall2 = 0; take2 = 0;
      @(posedge clk); #1;
      check("rel.pcf",   pc2, RPC2 + 4);
      check("rel.pcd",   pcd2, RPC2);
      check("rel.valid", {31'd0, valid2}, 32'd1);
      check("rel.cnt",   {30'd0, cnt2}, 32'd0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
